// File: rtl/norm_sel_gen.sv
// Leading-nonzero-pair select generator for the FP normalizer: scans the
// mantissa one 2-bit group per clock, MSB group first, behind valid/ready handshakes.
module norm_sel_gen #(
  parameter int unsigned N_GROUPS = 8,
  parameter int unsigned SEL_W    = 3
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iValid,
  output logic                  oReady,
  input  logic [2*N_GROUPS-1:0] iData,
  output logic                  oValid,
  input  logic                  iReady,
  output logic [SEL_W-1:0]      oSel,
  output logic [1:0]            oPair,
  output logic [SEL_W:0]        oShift,
  output logic [2*N_GROUPS-1:0] oNorm,
  output logic                  oZero
);

  localparam int unsigned DW = 2 * N_GROUPS;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  state_e          state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [DW-1:0]    data_q, data_d;
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [1:0]       pair_q, pair_d;
  logic [SEL_W:0]   shift_q, shift_d;
  logic [DW-1:0]    norm_q, norm_d;
  logic             zero_q, zero_d;

  logic [1:0]       grp;
  logic [SEL_W-1:0] inv_idx;
  logic [SEL_W:0]   shift_c;

  // Shift = two bits per skipped group, plus one when the leading pair is 2'b01.
  always_comb begin
    grp     = data_q[{idx_q, 1'b0} +: 2];
    inv_idx = SEL_W'(N_GROUPS - 1) - idx_q;
    shift_c = {inv_idx, 1'b0} + {{SEL_W{1'b0}}, (grp == 2'b01)};
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= IDLE;
      idx_q   <= SEL_W'(N_GROUPS - 1);
      data_q  <= '0;
      valid_q <= 1'b0;
      sel_q   <= '0;
      pair_q  <= '0;
      shift_q <= '0;
      norm_q  <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sel_q   <= sel_d;
      pair_q  <= pair_d;
      shift_q <= shift_d;
      norm_q  <= norm_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    valid_d = valid_q;
    sel_d   = sel_q;
    pair_d  = pair_q;
    shift_d = shift_q;
    norm_d  = norm_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (iValid) begin
          data_d  = iData;
          idx_d   = SEL_W'(N_GROUPS - 1);
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (grp != 2'b00) begin
          state_d = DONE;
          sel_d   = idx_q;
          pair_d  = grp;
          shift_d = shift_c;
          norm_d  = data_q << shift_c;
          zero_d  = 1'b0;
          valid_d = 1'b1;
        end else if (idx_q == '0) begin
          state_d = DONE;
          sel_d   = '0;
          pair_d  = '0;
          shift_d = '0;
          norm_d  = '0;
          zero_d  = 1'b1;
          valid_d = 1'b1;
        end else begin
          idx_d = idx_q - SEL_W'(1);
        end
      end
      DONE: begin
        if (iReady) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    oReady = (state_q == IDLE);
    oValid = valid_q;
    oSel   = sel_q;
    oPair  = pair_q;
    oShift = shift_q;
    oNorm  = norm_q;
    oZero  = zero_q;
  end

endmodule
